keypad_scanner: RTL and testbench

//  Input-side counterpart of the 4-digit display driver: time-multiplexed strobe out, hex nibble back.

---
 rtl/keypad_pkg.sv | 40 ++++
 rtl/GenericCounter.sv | 28 ++
 rtl/keypad_debounce.sv | 49 ++++
 rtl/keypad_scanner.sv | 157 +++++++++++++++
 tb/tb_keypad_scanner.sv | 222 ++++++++++++++++++++++
 5 files changed

// File: rtl/keypad_pkg.sv
// rtl/keypad_pkg.sv - shared types, key map and snapshot helpers for the keypad scanner
package keypad_pkg;

    localparam int NUM_COLS = 4;
    localparam int NUM_ROWS = 4;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_PRESSED = 2'd1,
        ST_MULTI   = 2'd2
    } state_t;

    // Snapshot bit 4*col+row -> hex legend; nibble i of this constant is bit i's key.
    localparam logic [63:0] KEY_MAP = 64'hDCBA_E963_F852_0741;

    function automatic logic [4:0] popcount16(input logic [15:0] v);
        logic [4:0] n;
        n = '0;
        for (int i = 0; i < 16; i++) begin
            n = n + 5'(v[i]);
        end
        return n;
    endfunction

    function automatic logic [3:0] onehot_index(input logic [15:0] v);
        logic [3:0] idx;
        idx = '0;
        for (int i = 0; i < 16; i++) begin
            if (v[i]) begin
                idx = 4'(i);
            end
        end
        return idx;
    endfunction

    function automatic logic [3:0] key_lookup(input logic [3:0] idx);
        return KEY_MAP[{idx, 2'b00} +: 4];
    endfunction

endpackage

// File: rtl/GenericCounter.sv
// rtl/GenericCounter.sv - free-running 0..COUNTER_MAX counter with terminal-count strobe
module GenericCounter #(
    parameter int COUNTER_WIDTH = 4,
    parameter int COUNTER_MAX   = 9
) (
    input  logic clk,
    input  logic reset,
    input  logic enable,
    output logic trig
);

    logic [COUNTER_WIDTH-1:0] count;

    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
        end else if (enable) begin
            if (count == COUNTER_WIDTH'(COUNTER_MAX)) begin
                count <= '0;
            end else begin
                count <= count + COUNTER_WIDTH'(1);
            end
        end
    end

    assign trig = enable && (count == COUNTER_WIDTH'(COUNTER_MAX));

endmodule

// File: rtl/keypad_debounce.sv
// rtl/keypad_debounce.sv - whole-keypad frame debouncer: accepts a snapshot after N identical frames
module keypad_debounce
    import keypad_pkg::*;
#(
    parameter int DEBOUNCE_FRAMES = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        frame_tick,
    input  logic [15:0] frame_data,
    output logic        accept,
    output logic [15:0] snapshot
);

    localparam int CW = $clog2(DEBOUNCE_FRAMES + 1);

    logic [15:0]   prev;
    logic [15:0]   accepted;
    logic [CW-1:0] stable_cnt;
    logic [CW-1:0] next_cnt;

    // Saturating at DEBOUNCE_FRAMES re-accepts every further stable frame, which the FSM treats as a no-op.
    always_comb begin
        next_cnt = stable_cnt;
        if (frame_data != prev) begin
            next_cnt = CW'(1);
        end else if (stable_cnt != CW'(DEBOUNCE_FRAMES)) begin
            next_cnt = stable_cnt + CW'(1);
        end
    end

    assign accept   = frame_tick && (next_cnt == CW'(DEBOUNCE_FRAMES));
    assign snapshot = accept ? frame_data : accepted;

    always_ff @(posedge clk) begin
        if (reset) begin
            prev       <= '0;
            stable_cnt <= '0;
            accepted   <= '0;
        end else if (frame_tick) begin
            prev       <= frame_data;
            stable_cnt <= next_cnt;
            if (accept) begin
                accepted <= frame_data;
            end
        end
    end

endmodule

// File: rtl/keypad_scanner.sv
// rtl/keypad_scanner.sv - 4x4 hex keypad column scanner with debounced key code and valid pulse
// Build macro KEYPAD_AUTOREPEAT_EN adds auto-repeat of KEY_VALID while a single key stays held.
module keypad_scanner
    import keypad_pkg::*;
#(
    parameter int SCAN_DIV        = 99999,
    parameter int DEBOUNCE_FRAMES = 4,
    parameter int REPEAT_FRAMES   = 125
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic [3:0] ROW_IN,
    output logic [3:0] COL_OUT,
    output logic [3:0] KEY_CODE,
    output logic       KEY_VALID,
    output logic       KEY_DOWN
);

    if (SCAN_DIV < 3 || DEBOUNCE_FRAMES < 1 || REPEAT_FRAMES < 1) begin : g_bad_params
        $error("keypad_scanner: parameter out of range");
    end

    logic [3:0]  row_meta;
    logic [3:0]  row_sync;
    logic [1:0]  col;
    logic [11:0] snap_lo;
    logic        tick;
    logic        frame_tick;
    logic        accept;
    logic [15:0] frame_data;
    logic [15:0] acc_snap;
    logic [4:0]  n_keys;
    logic [3:0]  hit_idx;
    logic [3:0]  held_idx;
    state_t      state;

`ifdef KEYPAD_AUTOREPEAT_EN
    localparam int REP_W = $clog2(REPEAT_FRAMES + 1);
    logic [REP_W-1:0] rep_cnt;
`endif

    GenericCounter #(
        .COUNTER_WIDTH ($clog2(SCAN_DIV + 1)),
        .COUNTER_MAX   (SCAN_DIV)
    ) u_dwell (
        .clk    (CLK),
        .reset  (RESET),
        .enable (1'b1),
        .trig   (tick)
    );

    always_ff @(posedge CLK) begin
        if (RESET) begin
            row_meta <= 4'hF;
            row_sync <= 4'hF;
        end else begin
            row_meta <= ROW_IN;
            row_sync <= row_meta;
        end
    end

    // Rows are sampled at the end of each column's dwell, long after the strobe and synchronizer settle.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            col     <= 2'd0;
            COL_OUT <= 4'b1110;
            snap_lo <= '0;
        end else if (tick) begin
            case (col)
                2'd0:    snap_lo[3:0]  <= ~row_sync;
                2'd1:    snap_lo[7:4]  <= ~row_sync;
                2'd2:    snap_lo[11:8] <= ~row_sync;
                default: ;
            endcase
            col     <= col + 2'd1;
            COL_OUT <= {COL_OUT[2:0], COL_OUT[3]};
        end
    end

    assign frame_tick = tick && (col == 2'd3);
    assign frame_data = {~row_sync, snap_lo};

    keypad_debounce #(
        .DEBOUNCE_FRAMES (DEBOUNCE_FRAMES)
    ) u_debounce (
        .clk        (CLK),
        .reset      (RESET),
        .frame_tick (frame_tick),
        .frame_data (frame_data),
        .accept     (accept),
        .snapshot   (acc_snap)
    );

    assign n_keys  = popcount16(acc_snap);
    assign hit_idx = onehot_index(acc_snap);

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state     <= ST_IDLE;
            KEY_CODE  <= '0;
            KEY_VALID <= 1'b0;
            KEY_DOWN  <= 1'b0;
            held_idx  <= '0;
`ifdef KEYPAD_AUTOREPEAT_EN
            rep_cnt   <= '0;
`endif
        end else begin
            KEY_VALID <= 1'b0;
            if (accept) begin
                case (state)
                    ST_IDLE: begin
                        if (n_keys == 5'd1) begin
                            state     <= ST_PRESSED;
                            KEY_CODE  <= key_lookup(hit_idx);
                            held_idx  <= hit_idx;
                            KEY_VALID <= 1'b1;
                            KEY_DOWN  <= 1'b1;
`ifdef KEYPAD_AUTOREPEAT_EN
                            rep_cnt   <= '0;
`endif
                        end else if (n_keys != 5'd0) begin
                            state <= ST_MULTI;
                        end
                    end
                    ST_PRESSED: begin
                        if (n_keys == 5'd0) begin
                            state    <= ST_IDLE;
                            KEY_DOWN <= 1'b0;
`ifdef KEYPAD_AUTOREPEAT_EN
                            rep_cnt  <= '0;
`endif
                        end else if (n_keys != 5'd1 || hit_idx != held_idx) begin
                            // A roll to another key must pass through an all-released frame to report it.
                            state    <= ST_MULTI;
                            KEY_DOWN <= 1'b0;
`ifdef KEYPAD_AUTOREPEAT_EN
                            rep_cnt  <= '0;
                        end else if (rep_cnt == REP_W'(REPEAT_FRAMES - 1)) begin
                            rep_cnt   <= '0;
                            KEY_VALID <= 1'b1;
                        end else begin
                            rep_cnt <= rep_cnt + REP_W'(1);
`endif
                        end
                    end
                    ST_MULTI: begin
                        if (n_keys == 5'd0) begin
                            state <= ST_IDLE;
                        end
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_keypad_scanner.sv
// tb/tb_keypad_scanner.sv - scoreboard bench for keypad_scanner with a column-strobed keypad model
module tb_keypad_scanner;

    localparam int SCAN_DIV = 3;
    localparam int DEB      = 2;
    localparam int REP      = 3;
    localparam int FRAME    = 4 * (SCAN_DIV + 1);

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [3:0]  row_in;
    logic [3:0]  col_out;
    logic [3:0]  key_code;
    logic        key_valid;
    logic        key_down;
    logic [15:0] keys = '0;

    int          checks = 0;
    int          errors = 0;
    logic [3:0]  exp_q[$];
    logic [3:0]  mon_exp;
    logic [3:0]  exp_cols[4];

    always #5 clk = ~clk;

    keypad_scanner #(
        .SCAN_DIV        (SCAN_DIV),
        .DEBOUNCE_FRAMES (DEB),
        .REPEAT_FRAMES   (REP)
    ) dut (
        .CLK       (clk),
        .RESET     (reset),
        .ROW_IN    (row_in),
        .COL_OUT   (col_out),
        .KEY_CODE  (key_code),
        .KEY_VALID (key_valid),
        .KEY_DOWN  (key_down)
    );

    // Key at bit 4*c+r pulls row r low while column c is strobed low.
    always_comb begin
        row_in = 4'hF;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                if (keys[4*c+r] && !col_out[c]) begin
                    row_in[r] = 1'b0;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (key_valid === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_pulse: got code %0h, expected no pulse", key_code);
            end else begin
                mon_exp = exp_q.pop_front();
                if (key_code !== mon_exp) begin
                    errors++;
                    $display("FAIL pulse_code: got %0h expected %0h", key_code, mon_exp);
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic frame_start();
        logic [3:0] last;
        bit         found;
        found = 1'b0;
        last  = col_out;
        for (int i = 0; i < 4 * FRAME && !found; i++) begin
            @(posedge clk);
            #1;
            if (col_out == 4'b1110 && last == 4'b0111) found = 1'b1;
            last = col_out;
        end
        check("frame_align", 32'(found), 32'd1);
    endtask

    initial begin
        exp_cols[0] = 4'b1110;
        exp_cols[1] = 4'b1101;
        exp_cols[2] = 4'b1011;
        exp_cols[3] = 4'b0111;

        reset = 1'b1;
        repeat (4) @(posedge clk);
        @(negedge clk);
        check("rst_col", col_out, 4'b1110);
        check("rst_code", key_code, 4'h0);
        check("rst_valid", key_valid, 1'b0);
        check("rst_down", key_down, 1'b0);
        @(posedge clk);
        #1;
        reset = 1'b0;

        @(negedge clk);
        check("scan_col0", col_out, exp_cols[0]);
        for (int k = 1; k < 4; k++) begin
            repeat (SCAN_DIV + 1) @(negedge clk);
            check($sformatf("scan_col%0d", k), col_out, exp_cols[k]);
        end

        // '8' held 10 frames, then released
        frame_start();
        keys[6] = 1'b1;
        exp_q.push_back(4'h8);
        cyc(10 * FRAME);
        @(negedge clk);
        check("k8_down", key_down, 1'b1);
        check("k8_pulsed", exp_q.size(), 0);
        keys = '0;
        cyc(4 * FRAME);
        @(negedge clk);
        check("k8_release_down", key_down, 1'b0);
        check("k8_code_held", key_code, 4'h8);

        // 'D' bouncing for two frames, then stable
        frame_start();
        for (int i = 0; i < 11; i++) begin
            keys[15] = ~keys[15];
            cyc(3);
        end
        keys[15] = 1'b1;
        exp_q.push_back(4'hD);
        cyc(6 * FRAME);
        @(negedge clk);
        check("kD_pulsed", exp_q.size(), 0);
        check("kD_down", key_down, 1'b1);
        keys = '0;
        cyc(4 * FRAME);

        // '1', then '5' added, '1' released, all released; then '2' proves return to idle
        frame_start();
        keys[0] = 1'b1;
        exp_q.push_back(4'h1);
        cyc(4 * FRAME);
        @(negedge clk);
        check("k1_pulsed", exp_q.size(), 0);
        check("k1_down", key_down, 1'b1);
        keys[5] = 1'b1;
        cyc(4 * FRAME);
        @(negedge clk);
        check("multi_down", key_down, 1'b0);
        check("multi_code", key_code, 4'h1);
        keys[0] = 1'b0;
        cyc(4 * FRAME);
        @(negedge clk);
        check("roll_down", key_down, 1'b0);
        check("roll_code", key_code, 4'h1);
        keys = '0;
        cyc(4 * FRAME);
        frame_start();
        keys[4] = 1'b1;
        exp_q.push_back(4'h2);
        cyc(4 * FRAME);
        @(negedge clk);
        check("k2_pulsed", exp_q.size(), 0);
        check("k2_code", key_code, 4'h2);
        keys = '0;
        cyc(4 * FRAME);

        // 'A' held through a mid-frame reset
        frame_start();
        keys[12] = 1'b1;
        exp_q.push_back(4'hA);
        cyc(4 * FRAME);
        @(negedge clk);
        check("kA_pulsed", exp_q.size(), 0);
        cyc(5);
        reset = 1'b1;
        cyc(1);
        reset = 1'b0;
        @(negedge clk);
        check("midrst_col", col_out, 4'b1110);
        check("midrst_code", key_code, 4'h0);
        check("midrst_down", key_down, 1'b0);
        exp_q.push_back(4'hA);
        cyc(5 * FRAME);
        @(negedge clk);
        check("kA_repulsed", exp_q.size(), 0);
        check("kA_down", key_down, 1'b1);
        keys = '0;
        cyc(4 * FRAME);

        // '0' held 12 frames
        frame_start();
        keys[3] = 1'b1;
        exp_q.push_back(4'h0);
`ifdef KEYPAD_AUTOREPEAT_EN
        exp_q.push_back(4'h0);
        exp_q.push_back(4'h0);
        exp_q.push_back(4'h0);
`endif
        cyc(12 * FRAME);
        keys = '0;
        cyc(4 * FRAME);
        @(negedge clk);
        check("k0_pulses", exp_q.size(), 0);
        check("k0_release_down", key_down, 1'b0);
        check("k0_code", key_code, 4'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
